// File: rtl/dsp_sequencer.sv
// Per-sample program sequencer: streams prog_len words from program RAM into the core, drains the pipeline, pulses done.
// Optional completed-frame counter is built only when DSP_SEQ_FRAME_COUNT_EN is defined.
module dsp_sequencer #(
  parameter int unsigned INSTR_WIDTH     = 26,
  parameter int unsigned PROG_ADDR_WIDTH = 10,
  parameter int unsigned PIPELINE_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       sample_tick,
  input  logic                       enable,
  input  logic [PROG_ADDR_WIDTH:0]   prog_len,
  output logic [PROG_ADDR_WIDTH-1:0] prog_rd_addr,
  input  logic [INSTR_WIDTH-1:0]     prog_rd_data,
  output logic [INSTR_WIDTH-1:0]     instruction,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun,
  input  logic                       overrun_clr,
  output logic [15:0]                frame_count
);

  localparam int unsigned LEN_W        = PROG_ADDR_WIDTH + 1;
  localparam int unsigned DRAIN_CYCLES = PIPELINE_DEPTH + 2;
  localparam int unsigned DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {PROG_ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                     state_q;
  logic [PROG_ADDR_WIDTH-1:0] last_addr_q;
  logic [DRAIN_W-1:0]         drain_cnt_q;
  logic                       fetch_valid_q;

  logic                       tick_ok_c;
  logic [PROG_ADDR_WIDTH-1:0] last_addr_c;

  // Storing len-1 keeps the end-of-program compare within the address width, so pc never wraps.
  assign tick_ok_c   = sample_tick & enable & (prog_len != '0);
  assign last_addr_c = (prog_len >= MAX_LEN) ? '1
                                             : PROG_ADDR_WIDTH'(prog_len - LEN_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      last_addr_q   <= '0;
      drain_cnt_q   <= '0;
      fetch_valid_q <= 1'b0;
      prog_rd_addr  <= '0;
      instruction   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      fetch_valid_q <= 1'b0;
      done          <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick_ok_c) begin
            state_q      <= S_RUN;
            prog_rd_addr <= '0;
            last_addr_q  <= last_addr_c;
            busy         <= 1'b1;
          end
        end
        S_RUN: begin
          fetch_valid_q <= 1'b1;
          if (prog_rd_addr == last_addr_q) begin
            state_q     <= S_DRAIN;
            drain_cnt_q <= '0;
          end else begin
            prog_rd_addr <= prog_rd_addr + PROG_ADDR_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            state_q <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
          end
        end
        S_DONE: begin
          // A tick landing on done starts the next frame back-to-back.
          if (tick_ok_c) begin
            state_q      <= S_RUN;
            prog_rd_addr <= '0;
            last_addr_q  <= last_addr_c;
            busy         <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      instruction <= fetch_valid_q ? prog_rd_data : '0;

      // Busy means RUN or DRAIN; a tick there is dropped and flagged. Set beats clear.
      if (sample_tick && busy) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef DSP_SEQ_FRAME_COUNT_EN
  logic [15:0] frame_count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
    end else if (done) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_dsp_sequencer.sv
// Scoreboard bench for dsp_sequencer: a cycle-timeline model queues expected words/done pulses per accepted tick.
module tb_dsp_sequencer;

  localparam int IW  = 26;
  localparam int AW  = 10;
  localparam int PD  = 4;
  localparam int MAX = 1 << AW;

  logic          clk;
  logic          reset_n;
  logic          sample_tick;
  logic          enable;
  logic [AW:0]   prog_len;
  logic [AW-1:0] prog_rd_addr;
  logic [IW-1:0] prog_rd_data;
  logic [IW-1:0] instruction;
  logic          busy;
  logic          done;
  logic          overrun;
  logic          overrun_clr;
  logic [15:0]   frame_count;

  dsp_sequencer #(.INSTR_WIDTH(IW), .PROG_ADDR_WIDTH(AW), .PIPELINE_DEPTH(PD)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_tick  (sample_tick),
    .enable       (enable),
    .prog_len     (prog_len),
    .prog_rd_addr (prog_rd_addr),
    .prog_rd_data (prog_rd_data),
    .instruction  (instruction),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr),
    .frame_count  (frame_count)
  );

  typedef struct packed {
    int            c;
    logic [IW-1:0] w;
  } exp_t;

  exp_t  iq[$];
  int    dq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    seed = 1;
  int    fr_start = -100;
  int    fr_done = -100;
  int    fr_len = 0;
  logic  exp_ovr = 1'b0;
  logic [15:0] exp_fc = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] ram_word(input int a, input int s);
    return IW'((a + 1) * 37 + s * 4099);
  endfunction

  // Synchronous program RAM: data one cycle after the address.
  always @(posedge clk) prog_rd_data <= ram_word(int'(prog_rd_addr), seed);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, act, exp);
    end
  endtask

  // Reference timeline: decides acceptance/overrun from inputs seen at each rising edge.
  always @(posedge clk) begin
    bit bsy;
    bit set;
    int l;
    if (reset_n) begin
      bsy = (cyc >= fr_start + 1) && (cyc <= fr_done - 1);
      set = 1'b0;
      if (sample_tick && bsy) begin
        set = 1'b1;
      end else if (sample_tick && enable && prog_len != '0) begin
        l = (int'(prog_len) > MAX) ? MAX : int'(prog_len);
        fr_start = cyc;
        fr_len   = l;
        fr_done  = cyc + l + PD + 3;
        for (int k = 0; k < l; k++) iq.push_back('{c: cyc + 3 + k, w: ram_word(k, seed)});
        dq.push_back(fr_done);
      end
      if (set) exp_ovr = 1'b1;
      else if (overrun_clr) exp_ovr = 1'b0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [IW-1:0] ei;
    bit ed;
    ei = '0;
    if (iq.size() != 0 && iq[0].c == cyc) begin
      ei = iq[0].w;
      void'(iq.pop_front());
    end
    check("instr", 32'(instruction), 32'(ei));
    ed = (dq.size() != 0 && dq[0] == cyc);
    if (ed) void'(dq.pop_front());
    check("done", 32'(done), 32'(ed));
    check("busy", 32'(busy), 32'((cyc >= fr_start + 1) && (cyc <= fr_done - 1)));
    if (cyc >= fr_start + 1 && cyc <= fr_start + fr_len)
      check("addr", 32'(prog_rd_addr), 32'(cyc - fr_start - 1));
    check("overrun", 32'(overrun), 32'(exp_ovr));
    check("fcount", 32'(frame_count), 32'(exp_fc));
`ifdef DSP_SEQ_FRAME_COUNT_EN
    if (ed) exp_fc = exp_fc + 16'd1;
`endif
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit t, input int len, input bit en, input bit clr);
    sample_tick = t;
    prog_len    = (AW + 1)'(len);
    enable      = en;
    overrun_clr = clr;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic flush_model();
    iq.delete();
    dq.delete();
    fr_start = -100;
    fr_done  = -100;
    fr_len   = 0;
    exp_ovr  = 1'b0;
    exp_fc   = '0;
  endtask

  initial begin
    reset_n     = 1'b1;
    sample_tick = 1'b0;
    enable      = 1'b0;
    prog_len    = '0;
    overrun_clr = 1'b0;
    #1 reset_n  = 1'b0;
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // Basic 3-word frame with an overrun tick at cycle 5 and set/clear collision at cycle 6.
    seed = 3;
    drive(1, 3, 1, 0);
    idle(4);
    drive(1, 3, 1, 0);
    drive(1, 3, 1, 1);
    idle(1);
    drive(0, 3, 1, 1);
    idle(8);

    // Back-to-back: second tick lands exactly on done.
    seed = 5;
    drive(1, 5, 1, 0);
    idle(5 + PD + 3 - 1);
    drive(1, 4, 1, 0);
    idle(4 + PD + 6);

    // Ignored ticks: zero length and disabled.
    drive(1, 0, 1, 0);
    idle(3);
    drive(1, 5, 0, 0);
    idle(12);

    // Full address space; prog_len and enable change mid-frame without effect.
    seed = 7;
    drive(1, 1024, 1, 0);
    prog_len = 11'd3;
    enable   = 1'b0;
    idle(MAX + PD + 6);
    seed = 9;
    drive(1, 2047, 1, 0);
    idle(MAX + PD + 6);

    // Reset mid-frame at cycle 4, then a clean frame.
    seed = 11;
    drive(1, 6, 1, 0);
    idle(3);
    reset_n = 1'b0;
    flush_model();
    idle(2);
    reset_n = 1'b1;
    idle(2);
    seed = 13;
    drive(1, 2, 1, 0);
    idle(2 + PD + 8);

    check("iq_empty", 32'(iq.size()), 32'd0);
    check("dq_empty", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_sequencer.md
# dsp_sequencer

Per-sample program sequencer for the DSP core. On each sample tick it streams a program of `prog_len` instruction words from a synchronous program RAM into the core's `instruction` input. It then issues NOPs until the core pipeline has drained, pulses `done`, and returns to idle. It also detects sample ticks that arrive while a frame is still running (overruns).

## Interface
- `INSTR_WIDTH`, default 26: instruction word width (6-bit opcode + 10-bit sample addr + 10-bit param addr).
- `PROG_ADDR_WIDTH`, default 10: program RAM address width.
- `PIPELINE_DEPTH`, default 4: core stages from instruction register to writeback (read, ex1, ex2, writeback).
- `clk` in, 1: single clock.
- `reset_n` in, 1: asynchronous, active-low reset.
- `sample_tick` in, 1: one-cycle pulse that starts a frame.
- `enable` in, 1: ticks are accepted only when high.
- `prog_len` in, PROG_ADDR_WIDTH+1: number of instructions per frame; latched at tick acceptance.
- `prog_rd_addr` out, PROG_ADDR_WIDTH: program RAM read address.
- `prog_rd_data` in, INSTR_WIDTH: RAM data, one cycle after the address.
- `instruction` out, INSTR_WIDTH: registered word to the core; all-zero (NOP) when not valid.
- `busy` out, 1: high in RUN and DRAIN.
- `done` out, 1: one-cycle pulse at frame completion.
- `overrun` out, 1: sticky flag, set by a tick dropped while busy.
- `overrun_clr` in, 1: clears `overrun`.
- `frame_count` out, 16: completed-frame counter (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset state is IDLE.
- Reset values: `instruction`=0, `prog_rd_addr`=0, `busy`=0, `done`=0, `overrun`=0, `frame_count`=0. pc, drain counter and fetch_valid are all 0.
- IDLE, on `sample_tick & enable & (prog_len != 0)`:
  - go to RUN, pc←0.
  - latch len←min(prog_len, 2^PROG_ADDR_WIDTH).
- IDLE, tick with `enable`=0 or `prog_len`=0: ignored. No state change, no `done`, no overrun.
- RUN:
  - `prog_rd_addr`=pc; pc increments each cycle; fetch_valid←1.
  - After the cycle with pc=len−1, go to DRAIN with drain counter←0.
  - pc never wraps, even when len=2^PROG_ADDR_WIDTH, because the last address is 2^W−1.
- DRAIN: fetch_valid←0. Stays for PIPELINE_DEPTH+2 cycles, then goes to DONE.
- DONE: `done`=1 for one cycle.
  - With a qualifying tick: go straight to RUN. This is not an overrun.
  - Otherwise: go to IDLE.
- Instruction register: `instruction` ← fetch_valid ? `prog_rd_data` : 0.
- Overrun:
  - A tick in RUN or DRAIN sets `overrun`. That tick is dropped and the current frame continues.
  - `overrun_clr` clears `overrun`; when both occur in the same cycle, set wins.
- `enable` falling mid-frame does not abort the frame; it only blocks later ticks.
- `prog_len` changes mid-frame have no effect until the next accepted tick.
- Reset asserted mid-frame: all registers return to their reset values immediately (asynchronously). `instruction` becomes NOP and no `done` is issued.

## Timing
- Tick accepted in cycle 0.
- `prog_rd_addr`=k in cycle 1+k.
- `instruction`=word k in cycle 3+k.
- Last word (k=L−1) appears on `instruction` in cycle L+2. The core writes it back at the end of cycle L+2+PIPELINE_DEPTH.
- `busy` is high for cycles 1 through L+PIPELINE_DEPTH+2.
- `done` is high in cycle L+PIPELINE_DEPTH+3 (L+7 at the default depth).
- Minimum tick period with no overrun is L+PIPELINE_DEPTH+3 cycles; a tick coinciding with `done` is accepted.
- `instruction` is NOP at every cycle outside 3..L+2.

## Configuration
- `DSP_SEQ_FRAME_COUNT_EN`:
  - Defined: `frame_count` increments (mod 2^16) in each cycle where `done`=1.
  - Undefined: no counter logic is built and `frame_count` is tied to 0. The port list is unchanged in both cases.

## Test plan
- prog_len=3, RAM words A,B,C; tick at cycle 0 → `instruction` = A,B,C in cycles 3–5 and 0 elsewhere; `done` in cycle 10; `busy` high in cycles 1–9.
- Tick at cycle 5 of the same frame → frame output unchanged; `overrun`=1; `overrun_clr` together with a new overrun in the same cycle → `overrun` stays 1.
- Tick coinciding with `done` → next frame's address 0 appears the following cycle; `overrun`=0; `frame_count` increments once per frame when the macro is defined.
- prog_len=0 tick, and enable=0 tick → no state change, `busy`=0, no `done`, `overrun`=0.
- prog_len=1024 (and prog_len=2047) → addresses 0..1023 each issued exactly once; `done` at cycle 1031.
- `reset_n` low at cycle 4 of a frame → `instruction`=0 and `busy`=0 immediately; no `done`; a tick after release starts a clean frame.
